// File: rtl/mem_port_sched.sv
// mem_port_sched: orders buffered committed stores and one speculative load onto the single memory data port
module mem_port_sched #(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_len,
    input  logic [31:0] st_data,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_len,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic        sb_empty,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_len,
    output logic [31:0] mem_w_data,
    input  logic        mem_done,
    input  logic [31:0] mem_r_data
);
    localparam int AW = $clog2(SB_DEPTH);
    typedef enum logic [1:0] {IDLE, LD, ST, GAP} state_t;
    state_t state, state_next;
    logic [31:0] sb_addr [SB_DEPTH];
    logic [2:0]  sb_len  [SB_DEPTH];
    logic [31:0] sb_data [SB_DEPTH];
    logic [AW-1:0] head, tail, off;
    logic [AW:0] count, count_next;
    logic full, nonempty, push, pop, addr_hit, blocked, issue_st, issue_ld, finish_ld;
    assign full = count == (AW+1)'(SB_DEPTH);
    assign nonempty = count != '0;
    assign st_ready = !full && rdy;
    assign push = st_valid && st_ready;
    assign blocked = nonempty && (addr_hit || ld_addr[17:16] == 2'b11);
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    // only entries between head and head+count are live
    always_comb begin
        addr_hit = 1'b0;
        off = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            off = AW'(i) - head;
            if ({1'b0, off} < count && sb_addr[i][31:2] == ld_addr[31:2]) addr_hit = 1'b1;
        end
    end
    always_comb begin
        state_next = state;
        issue_st = 1'b0;
        issue_ld = 1'b0;
        pop = 1'b0;
        finish_ld = 1'b0;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (!rollback && nonempty && (full || blocked || !ld_valid)) begin
                        issue_st = 1'b1;
                        state_next = ST;
                    end else if (!rollback && ld_valid) begin
                        issue_ld = 1'b1;
                        state_next = LD;
                    end
                end
                LD: begin
                    finish_ld = mem_done && !rollback;
                    state_next = (mem_done || rollback) ? GAP : LD;
                end
                ST: begin
                    pop = mem_done;
                    state_next = mem_done ? GAP : ST;
                end
                default: state_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= st_addr;
            sb_len[tail] <= st_len;
            sb_data[tail] <= st_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            mem_en <= 1'b0;
            mem_rw <= 1'b0;
            mem_addr <= '0;
            mem_len <= '0;
            mem_w_data <= '0;
            ld_done <= 1'b0;
            ld_data <= '0;
            sb_empty <= 1'b1;
        end else if (rdy) begin
            state <= state_next;
            head <= head + AW'(pop);
            tail <= tail + AW'(push);
            count <= count_next;
            ld_done <= finish_ld;
            sb_empty <= count_next == '0 && state_next != ST;
            if (finish_ld) ld_data <= mem_r_data;
            if (issue_st) begin
                mem_en <= 1'b1;
                mem_rw <= 1'b1;
                mem_addr <= sb_addr[head];
                mem_len <= sb_len[head];
                mem_w_data <= sb_data[head];
            end else if (issue_ld) begin
                mem_en <= 1'b1;
                mem_rw <= 1'b0;
                mem_addr <= ld_addr;
                mem_len <= ld_len;
                mem_w_data <= '0;
            end else if ((state == LD || state == ST) && state_next == GAP) begin
                mem_en <= 1'b0;
                mem_rw <= 1'b0;
            end
        end else begin
            ld_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: directed checks of mem_port_sched ordering, hazards, rollback and reset
module tb_mem_port_sched;
    logic clk = 0, rst = 1, rdy = 1, rollback = 0;
    logic st_valid = 0, ld_valid = 0, mem_done = 0;
    logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0, mem_r_data = 0;
    logic [2:0] st_len = 0, ld_len = 0;
    logic st_ready, ld_done, sb_empty, mem_en, mem_rw;
    logic [31:0] ld_data, mem_addr, mem_w_data;
    logic [2:0] mem_len;
    int checks = 0, passes = 0;

    mem_port_sched #(.SB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_len(st_len), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
        .sb_empty(sb_empty), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_w_data(mem_w_data), .mem_done(mem_done), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // buffer one store while rollback keeps IDLE from issuing
    task automatic push_hold(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1; st_addr = a; st_data = d; st_len = 4; rollback = 1;
        tick();
        st_valid = 0; rollback = 0;
    endtask

    task automatic done(input logic [31:0] rd);
        mem_done = 1; mem_r_data = rd;
        tick();
        mem_done = 0;
    endtask

    task automatic expect_req(input string tag, input logic rw, input logic [31:0] a);
        check({tag, "_en"}, mem_en, 1);
        check({tag, "_rw"}, mem_rw, rw);
        check({tag, "_addr"}, mem_addr, a);
    endtask

    initial begin
        tick(2);
        check("rst_en", mem_en, 0);
        check("rst_empty", sb_empty, 1);
        check("rst_ldd", ld_data, 0);
        check("rst_rdy", st_ready, 1);
        rst = 0;
        tick();

        // single load, done in fifth cycle
        ld_valid = 1; ld_addr = 32'h100; ld_len = 4;
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_req("ld1", 0, 32'h100);
            check("ld1_len", mem_len, 4);
            check("ld1_nodone", ld_done, 0);
            if (i == 4) done(32'hDEADBEEF);
            else tick();
        end
        ld_valid = 0;
        check("ld1_done", ld_done, 1);
        check("ld1_data", ld_data, 32'hDEADBEEF);
        check("ld1_gap", mem_en, 0);
        tick();
        check("ld1_pulse", ld_done, 0);
        check("ld1_hold", ld_data, 32'hDEADBEEF);

        // fill buffer back to back
        st_valid = 1; st_len = 4;
        for (int i = 0; i < 4; i++) begin
            st_addr = 32'h1000 + 4 * i; st_data = 32'hA0 + i;
            tick();
        end
        check("fill_full", st_ready, 0);
        st_valid = 0;
        for (int i = 0; i < 4; i++) begin
            expect_req("fill", 1, 32'h1000 + 4 * i);
            check("fill_wd", mem_w_data, 32'hA0 + i);
            check("fill_ne", sb_empty, 0);
            done(0);
            check("fill_gap", mem_en, 0);
            check("fill_empty", sb_empty, i == 3);
            tick();
            check("fill_idle", mem_en, 0);
            tick();
        end
        check("fill_stay", mem_en, 0);

        // same-word hazard: store first
        push_hold(32'h200, 32'h55);
        ld_valid = 1; ld_addr = 32'h202; ld_len = 2;
        tick();
        expect_req("haz_st", 1, 32'h200);
        done(0);
        check("haz_gap", mem_en, 0);
        tick();
        check("haz_idle", mem_en, 0);
        tick();
        expect_req("haz_ld", 0, 32'h202);
        check("haz_len", mem_len, 2);
        done(32'h00001234);
        ld_valid = 0;
        check("haz_data", ld_data, 32'h00001234);
        tick(2);

        // no hazard: load overtakes buffered store
        push_hold(32'h200, 32'h66);
        ld_valid = 1; ld_addr = 32'h300; ld_len = 4;
        tick();
        expect_req("nohaz_ld", 0, 32'h300);
        done(32'h11223344);
        ld_valid = 0;
        check("nohaz_done", ld_done, 1);
        tick(2);
        expect_req("nohaz_st", 1, 32'h200);
        check("nohaz_wd", mem_w_data, 32'h66);
        done(0);
        tick(2);

        // IO load waits for store
        push_hold(32'h30000, 32'h77);
        ld_valid = 1; ld_addr = 32'h30004; ld_len = 4;
        tick();
        expect_req("io_st", 1, 32'h30000);
        done(0);
        tick(2);
        expect_req("io_ld", 0, 32'h30004);
        done(32'h55667788);
        ld_valid = 0;
        check("io_data", ld_data, 32'h55667788);
        tick(2);

        // rollback mid-load
        ld_valid = 1; ld_addr = 32'h400; ld_len = 4;
        tick(3);
        expect_req("rb1", 0, 32'h400);
        rollback = 1; ld_valid = 0;
        tick();
        rollback = 0;
        check("rb1_en", mem_en, 0);
        check("rb1_nodone", ld_done, 0);
        tick();
        check("rb1_nodone2", ld_done, 0);
        tick();

        // rollback together with mem_done
        ld_valid = 1; ld_addr = 32'h500;
        tick(2);
        rollback = 1; ld_valid = 0;
        done(32'hBADBAD00);
        rollback = 0;
        check("rb2_nodone", ld_done, 0);
        check("rb2_en", mem_en, 0);
        check("rb2_data", ld_data, 32'h55667788);
        tick(2);

        // rollback ignored in ST
        push_hold(32'h600, 32'h88);
        tick();
        rollback = 1;
        tick();
        expect_req("rbst", 1, 32'h600);
        done(0);
        rollback = 0;
        check("rbst_en", mem_en, 0);
        check("rbst_empty", sb_empty, 1);
        tick(2);
        check("rbst_none", mem_en, 0);

        // rdy low blocks st_ready
        rdy = 0;
        #1 check("rdy_low", st_ready, 0);
        rdy = 1;

        // async reset during ST with 3 buffered
        push_hold(32'h700, 32'h1);
        push_hold(32'h704, 32'h2);
        push_hold(32'h708, 32'h3);
        tick();
        expect_req("ar", 1, 32'h700);
        check("ar_ne", sb_empty, 0);
        #2 rst = 1;
        #1;
        check("ar_en", mem_en, 0);
        check("ar_rw", mem_rw, 0);
        check("ar_addr", mem_addr, 0);
        check("ar_wd", mem_w_data, 0);
        check("ar_len", mem_len, 0);
        check("ar_ldd", ld_data, 0);
        check("ar_empty", sb_empty, 1);
        check("ar_ready", st_ready, 1);
        #2 rst = 0;
        tick(3);
        check("ar_drop", mem_en, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
